oam_dma_engine: RTL and testbench

Bus initiator that copies a block of bytes from CPU-side memory (work RAM and any other synchronous-read target on the CPU bus) into the sprite attribute (OAM) write port. It sits between the CPU-bus register decode and the video block. A page write (trigger) starts a fixed-length transfer that reads source bytes through the same CE/RnW/address/data interface the CPU uses. The engine is the initiator on that interface; the RAM is the responder.

---
 rtl/oam_dma_engine.sv | 143 ++++++++++++++
 tb/tb_oam_dma_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
// oam_dma_engine
// Copies LEN bytes from a CPU-bus source page into the sprite attribute (OAM)
// write port. The engine drives the CPU-bus CE/RnW/address lines itself. The
// responder returns read data one cycle after CE, and that data goes straight
// to the OAM write port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transfer; waiting for i_start
// STARTUP  | one-cycle gap after a trigger so the bus arbiter can settle
// XFER     | issuing one source read per granted cycle, rd_idx ascending
// DRAIN    | last read is in flight; its OAM write lands this cycle

module oam_dma_engine #(
    parameter int LEN    = 160,
    parameter int SRC_AW = 16
) (
    input  logic              i_clk_cpu,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [7:0]        i_page,
    input  logic              i_grant,
    output logic              o_ce,
    output logic              o_rnw,
    output logic [SRC_AW-1:0] o_addr,
    input  logic [7:0]        i_rdata,
    output logic              o_oam_we,
    output logic [7:0]        o_oam_addr,
    output logic [7:0]        o_oam_wdata,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STARTUP = 2'd1,
        ST_XFER    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [8:0] LAST_RD_IDX  = 9'(LEN - 1);
    localparam logic [7:0] LAST_OAM_IDX = 8'(LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        page_reg;
    logic [7:0]        page_nxt;
    logic [8:0]        rd_idx;
    logic [8:0]        rd_idx_nxt;
    logic              pend;
    logic [7:0]        pend_idx;
    logic              issue;
    logic [SRC_AW-1:0] page_base;

    // A read goes out on every granted cycle while transferring.
    always_comb begin
        issue = (state == ST_XFER) && i_grant;
    end

    // Next-state, page latch and read-index update; a trigger in any state
    // restarts from byte 0 of the new page.
    always_comb begin
        state_nxt  = state;
        page_nxt   = page_reg;
        rd_idx_nxt = rd_idx;
        if (i_start) begin
            state_nxt  = ST_STARTUP;
            page_nxt   = i_page;
            rd_idx_nxt = 9'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_STARTUP: begin
                    state_nxt = ST_XFER;
                end
                ST_XFER: begin
                    if (issue) begin
                        rd_idx_nxt = rd_idx + 9'd1;
                        if (rd_idx == LAST_RD_IDX) begin
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, page and read-index registers.
    always_ff @(posedge i_clk_cpu or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            page_reg <= 8'h00;
            rd_idx   <= 9'd0;
        end else begin
            state    <= state_nxt;
            page_reg <= page_nxt;
            rd_idx   <= rd_idx_nxt;
        end
    end

    // Write pipeline: remember which byte was read so the returning data is
    // written to the matching OAM slot next cycle. A read issued in the same
    // cycle as a restart still completes here with its old index.
    always_ff @(posedge i_clk_cpu or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend     <= 1'b0;
            pend_idx <= 8'h00;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_idx <= rd_idx[7:0];
            end
        end
    end

    // Source address: only the low byte of rd_idx is added, so the address
    // never carries out of the page (rd_idx reaches 256 only after the last
    // read of a 256-byte transfer, when no read is issued).
    always_comb begin
        page_base = SRC_AW'({page_reg, 8'h00});
        o_addr    = page_base + SRC_AW'(rd_idx[7:0]);
    end

    // Bus, OAM and status outputs.
    always_comb begin
        o_ce        = issue;
        o_rnw       = 1'b1;
        o_oam_we    = pend;
        o_oam_addr  = pend_idx;
        o_oam_wdata = i_rdata;
        o_busy      = (state != ST_IDLE) || pend;
        o_done      = pend && (pend_idx == LAST_OAM_IDX);
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: three builds (LEN=160, 1, 256) share a
// clock, reset, page and grant; each has its own trigger and read responder.
module tb_oam_dma_engine;

    localparam int LEN_A = 160;
    localparam int LEN_C = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b1;
    logic [7:0] page    = 8'h00;
    logic       grant   = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       start_c = 1'b0;

    logic        ce_a, rnw_a, we_a, busy_a, done_a;
    logic [15:0] addr_a;
    logic [7:0]  oaddr_a, wdata_a;
    logic [7:0]  rdata_a = 8'h00;

    logic        ce_b, rnw_b, we_b, busy_b, done_b;
    logic [15:0] addr_b;
    logic [7:0]  oaddr_b, wdata_b;
    logic [7:0]  rdata_b = 8'h00;

    logic        ce_c, rnw_c, we_c, busy_c, done_c;
    logic [15:0] addr_c;
    logic [7:0]  oaddr_c, wdata_c;
    logic [7:0]  rdata_c = 8'h00;

    int checks   = 0;
    int failures = 0;

    oam_dma_engine #(.LEN(LEN_A), .SRC_AW(16)) dut_a (
        .i_clk_cpu(clk), .i_reset_n(rst_n), .i_start(start_a), .i_page(page),
        .i_grant(grant), .o_ce(ce_a), .o_rnw(rnw_a), .o_addr(addr_a),
        .i_rdata(rdata_a), .o_oam_we(we_a), .o_oam_addr(oaddr_a),
        .o_oam_wdata(wdata_a), .o_busy(busy_a), .o_done(done_a)
    );

    oam_dma_engine #(.LEN(1), .SRC_AW(16)) dut_b (
        .i_clk_cpu(clk), .i_reset_n(rst_n), .i_start(start_b), .i_page(page),
        .i_grant(grant), .o_ce(ce_b), .o_rnw(rnw_b), .o_addr(addr_b),
        .i_rdata(rdata_b), .o_oam_we(we_b), .o_oam_addr(oaddr_b),
        .o_oam_wdata(wdata_b), .o_busy(busy_b), .o_done(done_b)
    );

    oam_dma_engine #(.LEN(LEN_C), .SRC_AW(16)) dut_c (
        .i_clk_cpu(clk), .i_reset_n(rst_n), .i_start(start_c), .i_page(page),
        .i_grant(grant), .o_ce(ce_c), .o_rnw(rnw_c), .o_addr(addr_c),
        .i_rdata(rdata_c), .o_oam_we(we_c), .o_oam_addr(oaddr_c),
        .o_oam_wdata(wdata_c), .o_busy(busy_c), .o_done(done_c)
    );

    // Source memory contents: page 0xC0 holds low^0x5A, other pages low^high.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        if (a[15:8] == 8'hC0) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous-read responders: data valid the cycle after CE.
    always @(posedge clk) if (ce_a) rdata_a <= src_byte(addr_a);
    always @(posedge clk) if (ce_b) rdata_b <= src_byte(addr_b);
    always @(posedge clk) if (ce_c) rdata_c <= src_byte(addr_c);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_stall(input int c, input int s1, input int s2, input int s3);
        return (c >= 2) && (c == s1 || c == s2 || c == s3);
    endfunction

    function automatic int stalls_before(input int c, input int s1, input int s2, input int s3);
        int n = 0;
        if (s1 >= 2 && s1 < c) n++;
        if (s2 >= 2 && s2 < c) n++;
        if (s3 >= 2 && s3 < c) n++;
        return n;
    endfunction

    task automatic test_reset();
        start_a = 0; start_b = 0; start_c = 0; grant = 1;
        rst_n = 1;
        #2;
        rst_n = 0;
        tick();
        tick();
        #1;
        checks++; if (ce_a !== 1'b0) begin failures++; $display("FAIL reset_ce got %b want 0", ce_a); end
        checks++; if (rnw_a !== 1'b1) begin failures++; $display("FAIL reset_rnw got %b want 1", rnw_a); end
        checks++; if (addr_a !== 16'h0000) begin failures++; $display("FAIL reset_addr got %h want 0000", addr_a); end
        checks++; if (we_a !== 1'b0) begin failures++; $display("FAIL reset_we got %b want 0", we_a); end
        checks++; if (oaddr_a !== 8'h00) begin failures++; $display("FAIL reset_oam_addr got %h want 00", oaddr_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done_a); end
        checks++; if (wdata_a !== rdata_a) begin failures++; $display("FAIL reset_wdata got %h want %h", wdata_a, rdata_a); end
        checks++; if (busy_b !== 1'b0 || busy_c !== 1'b0) begin failures++; $display("FAIL reset_busy_bc got %b%b want 00", busy_b, busy_c); end
        tick();
        rst_n = 1;
        tick();
        tick();
    endtask

    // LEN_A copy with up to three grant-stall cycles (0 = unused).
    task automatic run_copy(input string name, input logic [7:0] pg, input int s1, input int s2, input int s3);
        int   n_st;
        int   last_rd;
        int   exp_idx;
        int   exp_widx;
        logic exp_ce, exp_we, exp_busy, exp_done;
        n_st    = (s1 >= 2 ? 1 : 0) + (s2 >= 2 ? 1 : 0) + (s3 >= 2 ? 1 : 0);
        last_rd = LEN_A + 1 + n_st;
        tick();
        page = pg; start_a = 1; grant = 1;
        for (int c = 1; c <= LEN_A + n_st + 6; c++) begin
            tick();
            start_a = 0;
            grant   = !is_stall(c, s1, s2, s3);
            #1;
            exp_ce   = (c >= 2) && (c <= last_rd) && !is_stall(c, s1, s2, s3);
            exp_idx  = c - 2 - stalls_before(c, s1, s2, s3);
            exp_we   = (c >= 3) && (c - 1 <= last_rd) && !is_stall(c - 1, s1, s2, s3);
            exp_widx = c - 3 - stalls_before(c - 1, s1, s2, s3);
            exp_busy = (c <= LEN_A + 2 + n_st);
            exp_done = (c == LEN_A + 2 + n_st);
            checks++; if (ce_a !== exp_ce) begin failures++; $display("FAIL %s_ce cycle %0d got %b want %b", name, c, ce_a, exp_ce); end
            checks++; if (we_a !== exp_we) begin failures++; $display("FAIL %s_we cycle %0d got %b want %b", name, c, we_a, exp_we); end
            checks++; if (busy_a !== exp_busy) begin failures++; $display("FAIL %s_busy cycle %0d got %b want %b", name, c, busy_a, exp_busy); end
            checks++; if (done_a !== exp_done) begin failures++; $display("FAIL %s_done cycle %0d got %b want %b", name, c, done_a, exp_done); end
            if (exp_ce) begin
                checks++; if (addr_a !== {pg, exp_idx[7:0]}) begin failures++; $display("FAIL %s_addr cycle %0d got %h want %h", name, c, addr_a, {pg, exp_idx[7:0]}); end
            end
            if (exp_we) begin
                checks++; if (oaddr_a !== exp_widx[7:0]) begin failures++; $display("FAIL %s_oam_addr cycle %0d got %h want %h", name, c, oaddr_a, exp_widx[7:0]); end
                checks++; if (wdata_a !== src_byte({pg, exp_widx[7:0]})) begin failures++; $display("FAIL %s_oam_data cycle %0d got %h want %h", name, c, wdata_a, src_byte({pg, exp_widx[7:0]})); end
            end
        end
        grant = 1;
    endtask

    task automatic test_basic_copy();
        run_copy("basic", 8'hC0, 0, 0, 0);
    endtask

    task automatic test_grant_stalls();
        run_copy("stall", 8'hC0, 20, 77, 140);
    endtask

    task automatic test_restart();
        logic       exp_ce, exp_we, exp_busy, exp_done;
        logic [7:0] exp_pg;
        int         idx;
        tick();
        page = 8'hC0; start_a = 1; grant = 1;
        for (int c = 1; c <= 222; c++) begin
            tick();
            start_a = (c == 52);
            if (c == 52) page = 8'hD0;
            #1;
            exp_ce = (c >= 2 && c <= 52) || (c >= 54 && c <= 213);
            checks++; if (ce_a !== exp_ce) begin failures++; $display("FAIL restart_ce cycle %0d got %b want %b", c, ce_a, exp_ce); end
            if (exp_ce) begin
                idx    = (c <= 52) ? c - 2 : c - 54;
                exp_pg = (c <= 52) ? 8'hC0 : 8'hD0;
                checks++; if (addr_a !== {exp_pg, idx[7:0]}) begin failures++; $display("FAIL restart_addr cycle %0d got %h want %h", c, addr_a, {exp_pg, idx[7:0]}); end
            end
            exp_we = (c >= 3 && c <= 53) || (c >= 55 && c <= 214);
            checks++; if (we_a !== exp_we) begin failures++; $display("FAIL restart_we cycle %0d got %b want %b", c, we_a, exp_we); end
            if (exp_we) begin
                idx    = (c <= 53) ? c - 3 : c - 55;
                exp_pg = (c <= 53) ? 8'hC0 : 8'hD0;
                checks++; if (oaddr_a !== idx[7:0]) begin failures++; $display("FAIL restart_oam_addr cycle %0d got %h want %h", c, oaddr_a, idx[7:0]); end
                checks++; if (wdata_a !== src_byte({exp_pg, idx[7:0]})) begin failures++; $display("FAIL restart_oam_data cycle %0d got %h want %h", c, wdata_a, src_byte({exp_pg, idx[7:0]})); end
            end
            exp_done = (c == 214);
            exp_busy = (c <= 214);
            checks++; if (done_a !== exp_done) begin failures++; $display("FAIL restart_done cycle %0d got %b want %b", c, done_a, exp_done); end
            checks++; if (busy_a !== exp_busy) begin failures++; $display("FAIL restart_busy cycle %0d got %b want %b", c, busy_a, exp_busy); end
        end
    endtask

    task automatic test_async_reset();
        tick();
        page = 8'hC0; start_a = 1; grant = 1;
        for (int c = 1; c <= 82; c++) begin
            tick();
            start_a = 0;
        end
        #1;
        checks++; if (ce_a !== 1'b1 || addr_a !== 16'hC050) begin failures++; $display("FAIL areset_pre got ce=%b addr=%h want ce=1 addr=c050", ce_a, addr_a); end
        rst_n = 0;
        #1;
        checks++; if (ce_a !== 1'b0) begin failures++; $display("FAIL areset_ce got %b want 0", ce_a); end
        checks++; if (we_a !== 1'b0) begin failures++; $display("FAIL areset_we got %b want 0", we_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL areset_busy got %b want 0", busy_a); end
        checks++; if (oaddr_a !== 8'h00 || addr_a !== 16'h0000) begin failures++; $display("FAIL areset_addrs got %h/%h want 00/0000", oaddr_a, addr_a); end
        tick();
        tick();
        rst_n = 1;
        for (int c = 0; c < 200; c++) begin
            tick();
            #1;
            checks++; if (we_a !== 1'b0) begin failures++; $display("FAIL post_reset_we cycle %0d got %b want 0", c, we_a); end
            checks++; if (ce_a !== 1'b0) begin failures++; $display("FAIL post_reset_ce cycle %0d got %b want 0", c, ce_a); end
            checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL post_reset_busy_done cycle %0d got %b%b want 00", c, busy_a, done_a); end
        end
        checks++; if (addr_a !== 16'h0000 || oaddr_a !== 8'h00) begin failures++; $display("FAIL post_reset_addrs got %h/%h want 0000/00", addr_a, oaddr_a); end
    endtask

    task automatic test_len1();
        logic exp_ce, exp_we, exp_busy;
        tick();
        page = 8'hFF; start_b = 1; grant = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_b = 0;
            #1;
            exp_ce   = (c == 2);
            exp_we   = (c == 3);
            exp_busy = (c <= 3);
            checks++; if (ce_b !== exp_ce) begin failures++; $display("FAIL len1_ce cycle %0d got %b want %b", c, ce_b, exp_ce); end
            checks++; if (we_b !== exp_we) begin failures++; $display("FAIL len1_we cycle %0d got %b want %b", c, we_b, exp_we); end
            checks++; if (done_b !== exp_we) begin failures++; $display("FAIL len1_done cycle %0d got %b want %b", c, done_b, exp_we); end
            checks++; if (busy_b !== exp_busy) begin failures++; $display("FAIL len1_busy cycle %0d got %b want %b", c, busy_b, exp_busy); end
            if (exp_ce) begin
                checks++; if (addr_b !== 16'hFF00) begin failures++; $display("FAIL len1_addr got %h want ff00", addr_b); end
            end
            if (exp_we) begin
                checks++; if (oaddr_b !== 8'h00 || wdata_b !== 8'hFF) begin failures++; $display("FAIL len1_write got %h:%h want 00:ff", oaddr_b, wdata_b); end
            end
        end
    endtask

    task automatic test_len256();
        logic exp_ce, exp_we, exp_busy, exp_done;
        int   idx;
        tick();
        page = 8'hFF; start_c = 1; grant = 1;
        for (int c = 1; c <= 262; c++) begin
            tick();
            start_c = 0;
            #1;
            exp_ce   = (c >= 2 && c <= 257);
            exp_we   = (c >= 3 && c <= 258);
            exp_busy = (c <= 258);
            exp_done = (c == 258);
            checks++; if (ce_c !== exp_ce) begin failures++; $display("FAIL len256_ce cycle %0d got %b want %b", c, ce_c, exp_ce); end
            checks++; if (we_c !== exp_we) begin failures++; $display("FAIL len256_we cycle %0d got %b want %b", c, we_c, exp_we); end
            checks++; if (busy_c !== exp_busy) begin failures++; $display("FAIL len256_busy cycle %0d got %b want %b", c, busy_c, exp_busy); end
            checks++; if (done_c !== exp_done) begin failures++; $display("FAIL len256_done cycle %0d got %b want %b", c, done_c, exp_done); end
            checks++; if (addr_c[15:8] !== 8'hFF) begin failures++; $display("FAIL len256_page cycle %0d got %h want ff", c, addr_c[15:8]); end
            if (exp_ce) begin
                idx = c - 2;
                checks++; if (addr_c !== {8'hFF, idx[7:0]}) begin failures++; $display("FAIL len256_addr cycle %0d got %h want %h", c, addr_c, {8'hFF, idx[7:0]}); end
            end
            if (exp_we) begin
                idx = c - 3;
                checks++; if (oaddr_c !== idx[7:0]) begin failures++; $display("FAIL len256_oam_addr cycle %0d got %h want %h", c, oaddr_c, idx[7:0]); end
                checks++; if (wdata_c !== (idx[7:0] ^ 8'hFF)) begin failures++; $display("FAIL len256_oam_data cycle %0d got %h want %h", c, wdata_c, idx[7:0] ^ 8'hFF); end
            end
        end
    endtask

    // Retrigger in the final-write cycle: that write and its done still occur.
    task automatic test_back_to_back();
        logic exp_ce, exp_we, exp_busy;
        tick();
        page = 8'hFF; start_b = 1; grant = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start_b = (c == 3);
            if (c == 3) page = 8'hC0;
            #1;
            exp_ce   = (c == 2) || (c == 5);
            exp_we   = (c == 3) || (c == 6);
            exp_busy = (c <= 6);
            checks++; if (ce_b !== exp_ce) begin failures++; $display("FAIL b2b_ce cycle %0d got %b want %b", c, ce_b, exp_ce); end
            checks++; if (we_b !== exp_we) begin failures++; $display("FAIL b2b_we cycle %0d got %b want %b", c, we_b, exp_we); end
            checks++; if (done_b !== exp_we) begin failures++; $display("FAIL b2b_done cycle %0d got %b want %b", c, done_b, exp_we); end
            checks++; if (busy_b !== exp_busy) begin failures++; $display("FAIL b2b_busy cycle %0d got %b want %b", c, busy_b, exp_busy); end
            if (c == 5) begin
                checks++; if (addr_b !== 16'hC000) begin failures++; $display("FAIL b2b_addr got %h want c000", addr_b); end
            end
            if (c == 3) begin
                checks++; if (wdata_b !== 8'hFF) begin failures++; $display("FAIL b2b_data1 got %h want ff", wdata_b); end
            end
            if (c == 6) begin
                checks++; if (wdata_b !== 8'h5A) begin failures++; $display("FAIL b2b_data2 got %h want 5a", wdata_b); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_grant_stalls();
        test_restart();
        test_async_reset();
        test_len1();
        test_len256();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
